ft245_sync_dev: RTL and testbench

Device-side model of the FT245-style synchronous FIFO bus: it plays the USB-chip end of the interface that our host-side USB read/write controller drives. It exposes usb_rxf_n/usb_txe_n status, responds to usb_oe_n/usb_rd_n/usb_wr_n strobes, and owns the bidirectional usb_data bus. Two internal FIFOs back the bus: RX (PC→FPGA direction, filled from the host port) and TX (FPGA→PC direction, drained to the host port). It is used in loopback benches and in FPGA-to-FPGA bridge builds in place of the physical USB chip.

---
 rtl/ft245_sync_dev.sv | 109 ++++++++++
 tb/tb_ft245_sync_dev.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_sync_dev.sv
// Device end of an FT245-style synchronous FIFO bus: RX (host -> bus) and TX (bus -> host)
// FWFT FIFOs, registered status flags, sticky protocol-error and send-immediate indicators.
module ft245_sync_dev #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              usb_clk_60m,
    input  logic              sys_rst,
    output logic              usb_rxf_n,
    output logic              usb_txe_n,
    input  logic              usb_oe_n,
    input  logic              usb_rd_n,
    input  logic              usb_wr_n,
    input  logic              usb_siwu_n,
    inout  wire  [7:0]        usb_data,
    input  logic              host_wr_en,
    input  logic [7:0]        host_wr_data,
    output logic              host_full,
    input  logic              host_rd_en,
    output logic [7:0]        host_rd_data,
    output logic              host_empty,
    output logic [ADDR_W:0]   rx_level,
    output logic [ADDR_W:0]   tx_level,
    output logic [3:0]        err_flags,
    output logic              siwu_seen
);

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        rx_mem [DEPTH];
    logic [7:0]        tx_mem [DEPTH];
    logic [ADDR_W-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [ADDR_W-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [ADDR_W:0]   rx_level_next, tx_level_next;
    logic              rx_push, rx_pop, tx_push, tx_pop;
    logic [3:0]        err_now;
    logic [7:0]        rx_head;

    always_comb begin
        rx_push = host_wr_en && !host_full;
        rx_pop  = !usb_rd_n && !usb_oe_n && !usb_rxf_n;
        tx_push = !usb_wr_n && !usb_txe_n && usb_oe_n;
        tx_pop  = host_rd_en && !host_empty;

        err_now[0] = !usb_oe_n && !usb_wr_n;
        err_now[1] = !usb_rd_n && usb_oe_n;
        err_now[2] = !usb_wr_n && usb_txe_n;
        err_now[3] = !usb_rd_n && !usb_oe_n && usb_rxf_n;

        rx_level_next = rx_level;
        if (rx_push && !rx_pop)
            rx_level_next = rx_level + LVL_ONE;
        else if (!rx_push && rx_pop)
            rx_level_next = rx_level - LVL_ONE;

        tx_level_next = tx_level;
        if (tx_push && !tx_pop)
            tx_level_next = tx_level + LVL_ONE;
        else if (!tx_push && tx_pop)
            tx_level_next = tx_level - LVL_ONE;
    end

    // The FPGA samples usb_data on the popping edge, so the bus shows the pre-pop head.
    assign rx_head      = (rx_level == '0) ? 8'h00 : rx_mem[rx_rd_ptr];
    assign usb_data     = usb_oe_n ? 8'bz : rx_head;
    assign host_rd_data = tx_mem[tx_rd_ptr];

    // Storage carries no reset; pointers and levels alone define what is valid.
    always_ff @(posedge usb_clk_60m) begin
        if (rx_push)
            rx_mem[rx_wr_ptr] <= host_wr_data;
        if (tx_push)
            tx_mem[tx_wr_ptr] <= usb_data;
    end

    always_ff @(posedge usb_clk_60m) begin
        if (sys_rst) begin
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            tx_wr_ptr  <= '0;
            tx_rd_ptr  <= '0;
            rx_level   <= '0;
            tx_level   <= '0;
            usb_rxf_n  <= 1'b1;
            usb_txe_n  <= 1'b1;
            host_full  <= 1'b0;
            host_empty <= 1'b1;
            err_flags  <= '0;
            siwu_seen  <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            rx_level   <= rx_level_next;
            tx_level   <= tx_level_next;
            // Flags come from next-state levels so they are never a cycle stale.
            usb_rxf_n  <= (rx_level_next == '0);
            usb_txe_n  <= (tx_level_next == LVL_FULL);
            host_full  <= (rx_level_next == LVL_FULL);
            host_empty <= (tx_level_next == '0);
            err_flags  <= err_flags | err_now;
            siwu_seen  <= siwu_seen | !usb_siwu_n;
        end
    end

endmodule

// File: tb/tb_ft245_sync_dev.sv
// Directed bench for ft245_sync_dev: linear stimulus, queue scoreboards for RX and TX bytes.
module tb_ft245_sync_dev;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              usb_clk_60m = 1'b0;
    logic              sys_rst;
    logic              usb_rxf_n, usb_txe_n;
    logic              usb_oe_n, usb_rd_n, usb_wr_n, usb_siwu_n;
    wire  [7:0]        usb_data;
    logic              host_wr_en;
    logic [7:0]        host_wr_data;
    logic              host_full;
    logic              host_rd_en;
    logic [7:0]        host_rd_data;
    logic              host_empty;
    logic [ADDR_W:0]   rx_level, tx_level;
    logic [3:0]        err_flags;
    logic              siwu_seen;

    logic              tb_en;
    logic [7:0]        tb_drv;
    logic [7:0]        rxq[$];
    logic [7:0]        txq[$];
    logic [7:0]        exp_b;
    int                n_vec = 0;
    int                n_err = 0;

    assign usb_data = tb_en ? tb_drv : 8'bz;

    always #5 usb_clk_60m = ~usb_clk_60m;

    ft245_sync_dev #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .usb_clk_60m (usb_clk_60m),
        .sys_rst     (sys_rst),
        .usb_rxf_n   (usb_rxf_n),
        .usb_txe_n   (usb_txe_n),
        .usb_oe_n    (usb_oe_n),
        .usb_rd_n    (usb_rd_n),
        .usb_wr_n    (usb_wr_n),
        .usb_siwu_n  (usb_siwu_n),
        .usb_data    (usb_data),
        .host_wr_en  (host_wr_en),
        .host_wr_data(host_wr_data),
        .host_full   (host_full),
        .host_rd_en  (host_rd_en),
        .host_rd_data(host_rd_data),
        .host_empty  (host_empty),
        .rx_level    (rx_level),
        .tx_level    (tx_level),
        .err_flags   (err_flags),
        .siwu_seen   (siwu_seen)
    );

    task automatic tick();
        @(posedge usb_clk_60m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // With the bench driving a probe value, the bus only reads it back if the block has let go.
    task automatic chk_released(input string tag);
        tb_drv = 8'h5A;
        tb_en  = 1'b1;
        #1;
        chk(tag, {24'd0, usb_data}, 32'h5A);
        tb_en  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1; usb_oe_n = 1'b1; usb_rd_n = 1'b1; usb_wr_n = 1'b1; usb_siwu_n = 1'b1;
        host_wr_en = 1'b0; host_wr_data = 8'h00; host_rd_en = 1'b0; tb_en = 1'b0; tb_drv = 8'h00;

        // Reset
        tick(); tick();
        chk("rst_rxf_n",  {31'd0, usb_rxf_n},  32'd1);
        chk("rst_txe_n",  {31'd0, usb_txe_n},  32'd1);
        chk("rst_full",   {31'd0, host_full},  32'd0);
        chk("rst_empty",  {31'd0, host_empty}, 32'd1);
        chk("rst_rxlvl",  {27'd0, rx_level},   32'd0);
        chk("rst_txlvl",  {27'd0, tx_level},   32'd0);
        chk("rst_err",    {28'd0, err_flags},  32'd0);
        chk("rst_siwu",   {31'd0, siwu_seen},  32'd0);
        chk_released("rst_data_z");
        sys_rst = 1'b0;
        tick();
        chk("post_rst_txe_n", {31'd0, usb_txe_n}, 32'd0);
        chk("post_rst_rxf_n", {31'd0, usb_rxf_n}, 32'd1);

        // RX stream
        host_wr_en = 1'b1;
        host_wr_data = 8'hA1; rxq.push_back(8'hA1); tick();
        chk("rx_rxf_first", {31'd0, usb_rxf_n}, 32'd0);
        chk("rx_lvl_first", {27'd0, rx_level}, 32'd1);
        host_wr_data = 8'hA2; rxq.push_back(8'hA2); tick();
        host_wr_data = 8'hA3; rxq.push_back(8'hA3); tick();
        host_wr_en = 1'b0;
        chk("rx_lvl3", {27'd0, rx_level}, 32'd3);
        usb_oe_n = 1'b0; tick();
        usb_rd_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_b = rxq.pop_front();
            chk("rx_byte", {24'd0, usb_data}, {24'd0, exp_b});
            tick();
        end
        chk("rx_rxf_drained", {31'd0, usb_rxf_n}, 32'd1);
        chk("rx_lvl_drained", {27'd0, rx_level}, 32'd0);
        chk("rx_empty_bus",   {24'd0, usb_data}, 32'h00);
        tick();
        chk("rx_overread_err", {28'd0, err_flags}, 32'b1000);
        chk("rx_overread_lvl", {27'd0, rx_level}, 32'd0);
        usb_rd_n = 1'b1; usb_oe_n = 1'b1;

        // TX fill and overflow
        tb_en = 1'b1; usb_wr_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tb_drv = 8'(i); txq.push_back(8'(i));
            tick();
        end
        chk("tx_txe_full",  {31'd0, usb_txe_n},  32'd1);
        chk("tx_lvl_full",  {27'd0, tx_level},   32'd16);
        chk("tx_not_empty", {31'd0, host_empty}, 32'd0);
        tb_drv = 8'hFF; tick();
        chk("tx_ovf_err", {28'd0, err_flags}, 32'b1100);
        chk("tx_ovf_lvl", {27'd0, tx_level},  32'd16);
        usb_wr_n = 1'b1; tb_en = 1'b0;
        host_rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = txq.pop_front();
            chk("tx_drain", {24'd0, host_rd_data}, {24'd0, exp_b});
            tick();
            if (i == 0) chk("tx_txe_reopen", {31'd0, usb_txe_n}, 32'd0);
        end
        host_rd_en = 1'b0;
        chk("tx_empty_end", {31'd0, host_empty}, 32'd1);
        chk("tx_lvl_end",   {27'd0, tx_level},   32'd0);

        // Simultaneous RX push and bus pop
        host_wr_en = 1'b1; host_wr_data = 8'h77; rxq.push_back(8'h77); tick();
        host_wr_en = 1'b0;
        usb_oe_n = 1'b0; tick();
        usb_rd_n = 1'b0; host_wr_en = 1'b1; host_wr_data = 8'h55; rxq.push_back(8'h55);
        exp_b = rxq.pop_front();
        chk("sim_old_head", {24'd0, usb_data}, {24'd0, exp_b});
        tick();
        usb_rd_n = 1'b1; host_wr_en = 1'b0;
        chk("sim_lvl",      {27'd0, rx_level}, 32'd1);
        chk("sim_new_head", {24'd0, usb_data}, {24'd0, rxq[0]});

        // Contention: write strobe while the block owns the bus
        usb_wr_n = 1'b0; tick();
        usb_wr_n = 1'b1;
        chk("cont_err",  {28'd0, err_flags}, 32'b1101);
        chk("cont_txlvl", {27'd0, tx_level}, 32'd0);
        chk("cont_data", {24'd0, usb_data}, {24'd0, rxq[0]});
        usb_oe_n = 1'b1;

        // Read strobe without output enable, then send-immediate
        usb_rd_n = 1'b0; tick();
        usb_rd_n = 1'b1;
        chk("rd_no_oe_err", {28'd0, err_flags}, 32'b1111);
        chk("rd_no_oe_lvl", {27'd0, rx_level}, 32'd1);
        usb_siwu_n = 1'b0; tick();
        usb_siwu_n = 1'b1; tick();
        chk("siwu_sticky", {31'd0, siwu_seen}, 32'd1);

        // RX full and dropped host push
        host_wr_en = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            host_wr_data = 8'(8'h60 + i); rxq.push_back(8'(8'h60 + i));
            tick();
        end
        chk("rx_full_flag", {31'd0, host_full}, 32'd1);
        chk("rx_full_lvl",  {27'd0, rx_level}, 32'd16);
        host_wr_data = 8'hEE; tick();
        host_wr_en = 1'b0;
        chk("rx_drop_lvl", {27'd0, rx_level}, 32'd16);

        // Bring RX to 5 and TX to 7, then reset during an active read
        usb_oe_n = 1'b0; tick();
        usb_rd_n = 1'b0;
        for (int i = 0; i < 11; i++) begin
            exp_b = rxq.pop_front();
            chk("rx_bulk", {24'd0, usb_data}, {24'd0, exp_b});
            tick();
        end
        usb_rd_n = 1'b1; usb_oe_n = 1'b1;
        chk("pre_rst_rxlvl", {27'd0, rx_level}, 32'd5);
        tb_en = 1'b1; usb_wr_n = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tb_drv = 8'(8'hC0 + i); txq.push_back(8'(8'hC0 + i));
            tick();
        end
        usb_wr_n = 1'b1; tb_en = 1'b0;
        chk("pre_rst_txlvl", {27'd0, tx_level}, 32'd7);
        usb_oe_n = 1'b0; tick();
        usb_rd_n = 1'b0;
        chk("mid_rd_data", {24'd0, usb_data}, {24'd0, rxq[0]});
        sys_rst = 1'b1; tick();
        sys_rst = 1'b0; usb_rd_n = 1'b1; usb_oe_n = 1'b1;
        rxq.delete(); txq.delete();
        chk("mrst_rxlvl", {27'd0, rx_level},   32'd0);
        chk("mrst_txlvl", {27'd0, tx_level},   32'd0);
        chk("mrst_err",   {28'd0, err_flags},  32'd0);
        chk("mrst_rxf_n", {31'd0, usb_rxf_n},  32'd1);
        chk("mrst_empty", {31'd0, host_empty}, 32'd1);
        chk("mrst_siwu",  {31'd0, siwu_seen},  32'd0);
        chk_released("mrst_data_z");
        tick();
        chk("mrst_txe_n", {31'd0, usb_txe_n}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
